// File: rtl/lbist_prpg_if.sv
// LBIST PRPG control/status interface: master drives run control and seed, slave returns stimulus and status.
interface lbist_prpg_if #(
    parameter int unsigned N     = 24,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             hold;
    logic             seed_load;
    logic [N-1:0]     seed_in;
    logic [N-1:0]     pattern_out;
    logic             pattern_valid;
    logic             misr_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output start, abort, hold, seed_load, seed_in,
        input  pattern_out, pattern_valid, misr_en, busy, done, pat_cnt
    );

    modport slave (
        input  start, abort, hold, seed_load, seed_in,
        output pattern_out, pattern_valid, misr_en, busy, done, pat_cnt
    );
endinterface

// File: rtl/lbist_prpg.sv
// LBIST pseudo-random pattern generator: Galois LFSR stimulus source with MISR-aligned enable.
// Optional macro LBIST_PRPG_PHASE_SHIFT_EN XORs a 7-bit right rotation onto pattern_out.
module lbist_prpg #(
    parameter int unsigned N            = 24,
    parameter int unsigned SEED         = 100,
    parameter int unsigned NUM_PATTERNS = 1000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned CUT_LAT      = 2
) (
    input logic       clk,
    input logic       rst_n,
    lbist_prpg_if.slave bus
);
    localparam int unsigned DL_W = (CUT_LAT == 0) ? 1 : CUT_LAT;
    // Feedback mask includes bit 0, which receives r[N-1] directly
    localparam logic [N-1:0] TAPS = (N == 24) ? N'(32'h0000_0087) : N'(32'h0000_0021);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [3:0] FLUSH_INIT = (CUT_LAT > 0) ? 4'(CUT_LAT - 1) : 4'd0;
    localparam logic [N-1:0] SEED_N = N'(SEED);

    if (N != 23 && N != 24) begin : g_bad_n
        $error("lbist_prpg: unsupported N=%0d (only 23 or 24)", N);
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state;
    logic [N-1:0]     lfsr;
    logic [N-1:0]     pattern_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       flush_cnt;
    logic             done_q;
    logic [DL_W-1:0]  dly;
    logic             valid;
    logic [N-1:0]     seed_fix;

    function automatic logic [N-1:0] step(input logic [N-1:0] r);
        return {r[N-2:0], 1'b0} ^ ({N{r[N-1]}} & TAPS);
    endfunction

    function automatic logic [N-1:0] shape(input logic [N-1:0] r);
`ifdef LBIST_PRPG_PHASE_SHIFT_EN
        return r ^ {r[6:0], r[N-1:7]};
`else
        return r;
`endif
    endfunction

    // A counted pattern is one the LFSR advances past at the coming edge
    assign valid    = (state == RUN) && !bus.hold && !bus.abort;
    assign seed_fix = (bus.seed_in == '0) ? SEED_N : bus.seed_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED_N;
            pattern_q <= shape(SEED_N);
            cnt       <= '0;
            flush_cnt <= '0;
            done_q    <= 1'b0;
            dly       <= '0;
        end else begin
            dly <= (dly << 1) | DL_W'(valid);
            case (state)
                IDLE: begin
                    if (bus.seed_load) begin
                        lfsr      <= seed_fix;
                        pattern_q <= shape(seed_fix);
                        done_q    <= 1'b0;
                    end else if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        dly   <= '0;
                    end else if (!bus.hold) begin
                        lfsr      <= step(lfsr);
                        pattern_q <= shape(step(lfsr));
                        cnt       <= cnt + CNT_W'(1);
                        flush_cnt <= FLUSH_INIT;
                        if (cnt == LAST) begin
                            state <= (CUT_LAT > 0) ? FLUSH : DONE;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        dly   <= '0;
                    end else if (flush_cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    if (CUT_LAT == 0) begin : g_no_lat
        assign bus.misr_en = valid;
    end else begin : g_lat
        assign bus.misr_en = dly[DL_W-1];
    end

    assign bus.pattern_out   = pattern_q;
    assign bus.pattern_valid = valid;
    assign bus.busy          = (state == RUN) || (state == FLUSH);
    assign bus.done          = done_q;
    assign bus.pat_cnt       = cnt;
endmodule
